// File: rtl/gemm_stream_engine_if.sv
// gemm_stream_engine_if: operand write port, start/scale controls and result stream of gemm_stream_engine.
interface gemm_stream_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int M_DIM      = 4,
    parameter int N_DIM      = 4,
    parameter int K_DIM      = 4
);
    localparam int MK = M_DIM * K_DIM;
    localparam int KN = K_DIM * N_DIM;
    localparam int MN = M_DIM * N_DIM;
    localparam int MX = (MK > KN) ? ((MK > MN) ? MK : MN) : ((KN > MN) ? KN : MN);
    localparam int AW = (MX > 1) ? $clog2(MX) : 1;
    localparam int RW = (M_DIM > 1) ? $clog2(M_DIM) : 1;
    localparam int CW = (N_DIM > 1) ? $clog2(N_DIM) : 1;

    logic                         istart;
    logic signed [DATA_WIDTH-1:0] ialpha;
    logic signed [DATA_WIDTH-1:0] ibeta;
    logic                         iwr_en;
    logic [1:0]                   iwr_sel;
    logic [AW-1:0]                iwr_addr;
    logic signed [DATA_WIDTH-1:0] iwr_data;
    logic                         ores_valid;
    logic                         ires_ready;
    logic signed [DATA_WIDTH-1:0] ores_data;
    logic [RW-1:0]                ores_row;
    logic [CW-1:0]                ores_col;
    logic                         obusy;
    logic                         odone;
    logic                         oerr;

    modport master (
        output istart, ialpha, ibeta, iwr_en, iwr_sel, iwr_addr, iwr_data, ires_ready,
        input  ores_valid, ores_data, ores_row, ores_col, obusy, odone, oerr
    );

    modport slave (
        input  istart, ialpha, ibeta, iwr_en, iwr_sel, iwr_addr, iwr_data, ires_ready,
        output ores_valid, ores_data, ores_row, ores_col, obusy, odone, oerr
    );
endinterface

// File: rtl/gemm_stream_engine.sv
// gemm_stream_engine: streams R = (alpha*A*B + beta*C) >>> FRAC_BITS one element at a time, row-major.
// Define GEMM_SAT_EN to saturate results to DATA_WIDTH; otherwise results wrap.
module gemm_stream_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int M_DIM      = 4,
    parameter int N_DIM      = 4,
    parameter int K_DIM      = 4,
    parameter int FRAC_BITS  = 0
) (
    input  logic              iclk,
    input  logic              irst_n,
    gemm_stream_engine_if.slave bus
);
    localparam int MK = M_DIM * K_DIM;
    localparam int KN = K_DIM * N_DIM;
    localparam int MN = M_DIM * N_DIM;
    localparam int MX = (MK > KN) ? ((MK > MN) ? MK : MN) : ((KN > MN) ? KN : MN);
    localparam int AW = (MX > 1) ? $clog2(MX) : 1;
    localparam int RW = (M_DIM > 1) ? $clog2(M_DIM) : 1;
    localparam int CW = (N_DIM > 1) ? $clog2(N_DIM) : 1;
    localparam int KW = (K_DIM > 1) ? $clog2(K_DIM) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = DATA_WIDTH + ACC_WIDTH + 1;
    localparam logic [AW:0] A_SZ = (AW + 1)'(MK);
    localparam logic [AW:0] B_SZ = (AW + 1)'(KN);
    localparam logic [AW:0] C_SZ = (AW + 1)'(MN);
    localparam logic signed [SW-1:0] SMAX = {{(SW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MAC, SCALE, OUT, DONE} state_t;

    state_t state, state_nx;

    logic signed [DATA_WIDTH-1:0] a_mem [2**AW];
    logic signed [DATA_WIDTH-1:0] b_mem [2**AW];
    logic signed [DATA_WIDTH-1:0] c_mem [2**AW];

    logic [RW-1:0]                row;
    logic [CW-1:0]                col;
    logic [KW-1:0]                k;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [DATA_WIDTH-1:0] alpha_q, beta_q, res_q;
    logic                         oerr_q;

    logic [AW-1:0]                a_idx, b_idx, c_idx;
    logic signed [PW-1:0]         prod;
    logic signed [SW-1:0]         ax, bx, sum;
    logic signed [DATA_WIDTH-1:0] res;
    logic                         last_k, last_col, last_row, wr_ok;

    always_comb begin
        a_idx    = AW'(int'(row) * K_DIM + int'(k));
        b_idx    = AW'(int'(k) * N_DIM + int'(col));
        c_idx    = AW'(int'(row) * N_DIM + int'(col));
        prod     = PW'(a_mem[a_idx]) * PW'(b_mem[b_idx]);
        ax       = SW'(alpha_q) * SW'(acc);
        bx       = SW'(beta_q) * SW'(c_mem[c_idx]);
        sum      = (ax + bx) >>> FRAC_BITS;
        last_k   = k == KW'(K_DIM - 1);
        last_col = col == CW'(N_DIM - 1);
        last_row = row == RW'(M_DIM - 1);
        wr_ok    = (state == IDLE) && bus.iwr_en;
`ifdef GEMM_SAT_EN
        res = (sum > SMAX) ? DATA_WIDTH'(SMAX) : (sum < SMIN) ? DATA_WIDTH'(SMIN) : DATA_WIDTH'(sum);
`else
        res = DATA_WIDTH'(sum);
`endif
    end

    // Operand storage is deliberately unreset so loaded matrices survive an aborted job.
    always_ff @(posedge iclk) begin
        if (wr_ok && bus.iwr_sel == 2'd0 && {1'b0, bus.iwr_addr} < A_SZ) a_mem[bus.iwr_addr] <= bus.iwr_data;
        if (wr_ok && bus.iwr_sel == 2'd1 && {1'b0, bus.iwr_addr} < B_SZ) b_mem[bus.iwr_addr] <= bus.iwr_data;
        if (wr_ok && bus.iwr_sel == 2'd2 && {1'b0, bus.iwr_addr} < C_SZ) c_mem[bus.iwr_addr] <= bus.iwr_data;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.istart ? MAC : IDLE;
            MAC:     state_nx = last_k ? SCALE : MAC;
            SCALE:   state_nx = OUT;
            OUT:     state_nx = !bus.ires_ready ? OUT : (last_row && last_col) ? DONE : MAC;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.ores_valid = state == OUT;
        bus.obusy      = state != IDLE;
        bus.odone      = state == DONE;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            row     <= '0;
            col     <= '0;
            k       <= '0;
            acc     <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            res_q   <= '0;
            oerr_q  <= 1'b0;
        end else begin
            oerr_q <= (state != IDLE) && (bus.istart || bus.iwr_en);
            if (state == IDLE && bus.istart) begin
                row     <= '0;
                col     <= '0;
                k       <= '0;
                acc     <= '0;
                alpha_q <= bus.ialpha;
                beta_q  <= bus.ibeta;
            end
            // The first MAC cycle of each element discards the previous sum.
            if (state == MAC) begin
                acc <= ((k == '0) ? '0 : acc) + ACC_WIDTH'(prod);
                k   <= last_k ? '0 : k + KW'(1);
            end
            if (state == SCALE) res_q <= res;
            if (state == OUT && bus.ires_ready) begin
                col <= last_col ? '0 : col + CW'(1);
                if (last_col) row <= last_row ? '0 : row + RW'(1);
            end
        end
    end

    assign bus.ores_data = res_q;
    assign bus.ores_row  = row;
    assign bus.ores_col  = col;
    assign bus.oerr      = oerr_q;
endmodule

// File: tb/tb_gemm_stream_engine.sv
// tb_gemm_stream_engine: directed scenarios for gemm_stream_engine at 4x4x4, DATA_WIDTH=16.
module tb_gemm_stream_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gemm_stream_engine_if #(.DATA_WIDTH(16), .M_DIM(4), .N_DIM(4), .K_DIM(4)) bus ();

    gemm_stream_engine #(
        .DATA_WIDTH(16), .ACC_WIDTH(40), .M_DIM(4), .N_DIM(4), .K_DIM(4), .FRAC_BITS(0)
    ) dut (
        .iclk(clk),
        .irst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic signed [15:0] out_d[$];
    int out_r[$];
    int out_c[$];
    logic signed [15:0] stall_d[$];
    int stall_rc[$];
    int oerr_cnt;
    int cyc;
    logic signed [15:0] exp_d[16];

    task automatic wr(input logic [1:0] s, input int a, input int d);
        @(negedge clk);
        bus.iwr_en   = 1'b1;
        bus.iwr_sel  = s;
        bus.iwr_addr = 4'(a);
        bus.iwr_data = 16'(d);
        @(negedge clk);
        bus.iwr_en = 1'b0;
    endtask

    task automatic load_identity();
        for (int i = 0; i < 16; i++) begin
            wr(2'd0, i, (i / 4 == i % 4) ? 1 : 0);
            wr(2'd1, i, i + 1);
            wr(2'd2, i, 0);
        end
        bus.ialpha = 16'sd1;
        bus.ibeta  = 16'sd0;
        for (int i = 0; i < 16; i++) exp_d[i] = 16'(i + 1);
    endtask

    // Starts a job and records every handshaken result until odone or a cycle budget runs out.
    task automatic run_job(input int stall_idx, input int stall_len, input int inject_at,
                           input logic wws, input logic [1:0] wsel, input int waddr, input int wdata);
        int st = 0;
        out_d.delete(); out_r.delete(); out_c.delete();
        stall_d.delete(); stall_rc.delete();
        oerr_cnt = 0;
        cyc = -1;
        @(negedge clk);
        bus.istart = 1'b1;
        if (wws) begin
            bus.iwr_en   = 1'b1;
            bus.iwr_sel  = wsel;
            bus.iwr_addr = 4'(waddr);
            bus.iwr_data = 16'(wdata);
        end
        @(negedge clk);
        bus.istart = 1'b0;
        bus.iwr_en = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (bus.oerr) oerr_cnt++;
            if (bus.odone) begin
                cyc = n;
                break;
            end
            bus.iwr_en = (n == inject_at);
            if (n == inject_at) begin
                bus.iwr_sel  = 2'd0;
                bus.iwr_addr = 4'd0;
                bus.iwr_data = 16'sd99;
            end
            if (bus.ores_valid && out_d.size() == stall_idx && st < stall_len) begin
                bus.ires_ready = 1'b0;
                st++;
                stall_d.push_back(bus.ores_data);
                stall_rc.push_back(int'(bus.ores_row) * 4 + int'(bus.ores_col));
            end else begin
                bus.ires_ready = 1'b1;
                if (bus.ores_valid) begin
                    out_d.push_back(bus.ores_data);
                    out_r.push_back(int'(bus.ores_row));
                    out_c.push_back(int'(bus.ores_col));
                end
            end
            @(negedge clk);
        end
        bus.iwr_en     = 1'b0;
        bus.ires_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.ores_valid, bus.obusy, bus.odone, bus.oerr} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got v/b/d/e=%b, want 0000", {bus.ores_valid, bus.obusy, bus.odone, bus.oerr});
        end
        checks++;
        if ({bus.ores_data, bus.ores_row, bus.ores_col} !== 20'b0) begin
            errors++;
            $display("FAIL reset_data: got data=%h row=%0d col=%0d, want 0", bus.ores_data, bus.ores_row, bus.ores_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        load_identity();
        wr(2'd3, 0, 77);
        run_job(-1, 0, -1, 1'b0, 2'd0, 0, 0);
        checks++;
        if (cyc !== 96) begin
            errors++;
            $display("FAIL identity_latency: got %0d cycles, want 96", cyc);
        end
        checks++;
        if (out_d.size() !== 16) begin
            errors++;
            $display("FAIL identity_count: got %0d results, want 16", out_d.size());
        end
        for (int i = 0; i < out_d.size() && i < 16; i++) begin
            checks++;
            if (out_d[i] !== exp_d[i] || out_r[i] !== i / 4 || out_c[i] !== i % 4) begin
                errors++;
                $display("FAIL identity_elem%0d: got %0d at (%0d,%0d), want %0d at (%0d,%0d)",
                         i, out_d[i], out_r[i], out_c[i], exp_d[i], i / 4, i % 4);
            end
        end
    endtask

    task automatic test_scale_c();
        for (int i = 0; i < 16; i++) wr(2'd2, i, i - 8);
        bus.ialpha = 16'sd0;
        bus.ibeta  = 16'sd3;
        run_job(-1, 0, -1, 1'b0, 2'd0, 0, 0);
        checks++;
        if (out_d.size() !== 16) begin
            errors++;
            $display("FAIL scale_count: got %0d results, want 16", out_d.size());
        end
        for (int i = 0; i < out_d.size() && i < 16; i++) begin
            checks++;
            if (out_d[i] !== 16'(3 * (i - 8))) begin
                errors++;
                $display("FAIL scale_elem%0d: got %0d, want %0d", i, out_d[i], 3 * (i - 8));
            end
        end
    endtask

    task automatic test_stall();
        bus.ialpha = 16'sd1;
        bus.ibeta  = 16'sd0;
        run_job(6, 5, -1, 1'b0, 2'd0, 0, 0);
        checks++;
        if (cyc !== 101) begin
            errors++;
            $display("FAIL stall_latency: got %0d cycles, want 101", cyc);
        end
        checks++;
        if (stall_d.size() !== 5) begin
            errors++;
            $display("FAIL stall_len: got %0d held cycles, want 5", stall_d.size());
        end
        for (int i = 0; i < stall_d.size(); i++) begin
            checks++;
            if (stall_d[i] !== 16'sd7 || stall_rc[i] !== 6) begin
                errors++;
                $display("FAIL stall_hold%0d: got %0d at idx %0d, want 7 at idx 6", i, stall_d[i], stall_rc[i]);
            end
        end
        checks++;
        if (out_d.size() !== 16) begin
            errors++;
            $display("FAIL stall_count: got %0d results, want 16", out_d.size());
        end
        for (int i = 0; i < out_d.size() && i < 16; i++) begin
            checks++;
            if (out_d[i] !== 16'(i + 1) || out_r[i] !== i / 4 || out_c[i] !== i % 4) begin
                errors++;
                $display("FAIL stall_elem%0d: got %0d at (%0d,%0d), want %0d", i, out_d[i], out_r[i], out_c[i], i + 1);
            end
        end
    endtask

    task automatic test_write_and_start();
        load_identity();
        run_job(-1, 0, -1, 1'b1, 2'd1, 0, 50);
        exp_d[0] = 16'sd50;
        checks++;
        if (out_d.size() !== 16) begin
            errors++;
            $display("FAIL wrstart_count: got %0d results, want 16", out_d.size());
        end
        for (int i = 0; i < out_d.size() && i < 16; i++) begin
            checks++;
            if (out_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL wrstart_elem%0d: got %0d, want %0d", i, out_d[i], exp_d[i]);
            end
        end
        wr(2'd1, 0, 1);
    endtask

    task automatic test_busy_write();
        bus.ialpha = 16'sd1;
        bus.ibeta  = 16'sd0;
        run_job(-1, 0, 3, 1'b0, 2'd0, 0, 0);
        checks++;
        if (oerr_cnt !== 1) begin
            errors++;
            $display("FAIL busywr_oerr: got %0d pulse cycles, want 1", oerr_cnt);
        end
        checks++;
        if (cyc !== 96) begin
            errors++;
            $display("FAIL busywr_latency: got %0d cycles, want 96", cyc);
        end
        checks++;
        if (out_d.size() !== 16) begin
            errors++;
            $display("FAIL busywr_count: got %0d results, want 16", out_d.size());
        end
        for (int i = 0; i < out_d.size() && i < 16; i++) begin
            checks++;
            if (out_d[i] !== 16'(i + 1)) begin
                errors++;
                $display("FAIL busywr_elem%0d: got %0d, want %0d", i, out_d[i], i + 1);
            end
        end
        run_job(-1, 0, -1, 1'b0, 2'd0, 0, 0);
        checks++;
        if (out_d.size() < 1 || out_d[0] !== 16'sd1) begin
            errors++;
            $display("FAIL busywr_a0: got %0d results first=%0d, want first 1", out_d.size(),
                     out_d.size() > 0 ? out_d[0] : 16'sd0);
        end
    endtask

    task automatic test_overflow();
        logic signed [15:0] want;
`ifdef GEMM_SAT_EN
        want = 16'sh7FFF;
`else
        want = 16'sh0004;
`endif
        for (int i = 0; i < 16; i++) begin
            wr(2'd0, i, 32'h7FFF);
            wr(2'd1, i, 32'h7FFF);
        end
        bus.ialpha = 16'sd1;
        bus.ibeta  = 16'sd0;
        run_job(-1, 0, -1, 1'b0, 2'd0, 0, 0);
        checks++;
        if (out_d.size() !== 16) begin
            errors++;
            $display("FAIL ovf_count: got %0d results, want 16", out_d.size());
        end
        for (int i = 0; i < out_d.size() && i < 16; i++) begin
            checks++;
            if (out_d[i] !== want) begin
                errors++;
                $display("FAIL ovf_elem%0d: got %h, want %h", i, out_d[i], want);
            end
        end
    endtask

    task automatic test_abort_reset();
        logic found = 1'b0;
        int bad = 0;
        load_identity();
        @(negedge clk);
        bus.istart = 1'b1;
        @(negedge clk);
        bus.istart = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (bus.ores_row == 2'd2 && bus.ores_col == 2'd1 && bus.obusy && !bus.ores_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach: element (2,1) MAC not reached, got busy=%b", bus.obusy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ores_valid, bus.obusy, bus.odone, bus.oerr, bus.ores_data, bus.ores_row, bus.ores_col} !== 24'b0) begin
            errors++;
            $display("FAIL abort_outputs: got v/b/d/e=%b data=%h row=%0d col=%0d, want all 0",
                     {bus.ores_valid, bus.obusy, bus.odone, bus.oerr}, bus.ores_data, bus.ores_row, bus.ores_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bus.ores_valid || bus.odone || bus.obusy) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles after abort, want 0", bad);
        end
        run_job(-1, 0, -1, 1'b0, 2'd0, 0, 0);
        checks++;
        if (cyc !== 96 || out_d.size() !== 16) begin
            errors++;
            $display("FAIL abort_rerun: got %0d cycles %0d results, want 96 and 16", cyc, out_d.size());
        end
        for (int i = 0; i < out_d.size() && i < 16; i++) begin
            checks++;
            if (out_d[i] !== 16'(i + 1) || out_r[i] !== i / 4 || out_c[i] !== i % 4) begin
                errors++;
                $display("FAIL abort_elem%0d: got %0d at (%0d,%0d), want %0d", i, out_d[i], out_r[i], out_c[i], i + 1);
            end
        end
    endtask

    initial begin
        bus.istart     = 1'b0;
        bus.ialpha     = 16'sd0;
        bus.ibeta      = 16'sd0;
        bus.iwr_en     = 1'b0;
        bus.iwr_sel    = 2'd0;
        bus.iwr_addr   = 4'd0;
        bus.iwr_data   = 16'sd0;
        bus.ires_ready = 1'b1;
        test_reset();
        test_identity();
        test_scale_c();
        test_stall();
        test_write_and_start();
        test_busy_write();
        test_overflow();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
